// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef logic [1:0] grant_t;

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bundle (stall-based flow control) with master/slave views.
interface wishbone_if;
  import wb_arb_pkg::*;

  logic          cyc;
  logic          stb;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [SW-1:0] sel;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          err;
  logic          rty;
  logic          stall;

  modport MASTER (
    output cyc, stb, we, lock, addr, sel, wdata,
    input  rdata, ack, err, rty, stall
  );

  modport SLAVE (
    input  cyc, stb, we, lock, addr, sel, wdata,
    output rdata, ack, err, rty, stall
  );

endinterface

// File: rtl/wb_outstanding_cnt.sv
// Up/down count of issued-but-unanswered requests; o_full throttles new issues.
module wb_outstanding_cnt
  import wb_arb_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_issue,
  input  logic         i_retire,
  input  logic         i_clear,
  output logic [W-1:0] o_count,
  output logic         o_full
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_issue && !i_retire) begin
      r_count <= r_count + 1'b1;
    end else if (i_retire && !i_issue) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == W'(MAX));

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with outstanding-request throttling.
// Optional watchdog abort enabled by defining WB_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no grant; arbitrate registered on next edge
//   GNT0  | master 0 owns the slave port until cyc & lock both drop
//   GNT1  | master 1 owns the slave port until cyc & lock both drop
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 255
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wishbone_if.SLAVE  m0,
  wishbone_if.SLAVE  m1,
  wishbone_if.MASTER s,
  output grant_t     grant_o
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic          r_last;
  logic          w_req0, w_req1, w_g0, w_g1, w_granted;
  logic          w_cyc, w_stb, w_we, w_lock;
  logic [AW-1:0] w_addr;
  logic [SW-1:0] w_sel;
  logic [DW-1:0] w_wdata;
  logic          w_resp, w_release, w_tmo, w_issue, w_retire, w_full;
  logic [CW-1:0] w_count;

  assign w_req0    = m0.cyc & m0.stb;
  assign w_req1    = m1.cyc & m1.stb;
  assign w_g0      = (r_state == GNT0);
  assign w_g1      = (r_state == GNT1);
  assign w_granted = w_g0 | w_g1;
  assign grant_o   = {w_g1, w_g0};

  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    w_we    = 1'b0;
    w_lock  = 1'b0;
    w_addr  = '0;
    w_sel   = '0;
    w_wdata = '0;
    if (w_g0) begin
      w_cyc   = m0.cyc;
      w_stb   = m0.stb;
      w_we    = m0.we;
      w_lock  = m0.lock;
      w_addr  = m0.addr;
      w_sel   = m0.sel;
      w_wdata = m0.wdata;
    end else if (w_g1) begin
      w_cyc   = m1.cyc;
      w_stb   = m1.stb;
      w_we    = m1.we;
      w_lock  = m1.lock;
      w_addr  = m1.addr;
      w_sel   = m1.sel;
      w_wdata = m1.wdata;
    end
  end

  // A watchdog abort drops cyc for its cycle so the slave abandons the hung transfer.
  assign s.cyc   = w_cyc & ~w_tmo;
  assign s.stb   = w_cyc & w_stb & ~w_full & ~w_tmo;
  assign s.we    = w_we;
  assign s.lock  = w_lock;
  assign s.addr  = w_addr;
  assign s.sel   = w_sel;
  assign s.wdata = w_wdata;

  assign m0.stall = ~w_g0 | s.stall | w_full;
  assign m0.ack   = w_g0 & s.ack;
  assign m0.err   = w_g0 & (s.err | w_tmo);
  assign m0.rty   = w_g0 & s.rty;
  assign m0.rdata = w_g0 ? s.rdata : '0;

  assign m1.stall = ~w_g1 | s.stall | w_full;
  assign m1.ack   = w_g1 & s.ack;
  assign m1.err   = w_g1 & (s.err | w_tmo);
  assign m1.rty   = w_g1 & s.rty;
  assign m1.rdata = w_g1 ? s.rdata : '0;

  assign w_resp    = s.ack | s.err | s.rty;
  assign w_release = w_granted & ~w_cyc & ~w_lock;
  assign w_issue   = s.cyc & s.stb & ~s.stall;
  // Responses with nothing in flight belong to an aborted grant and are ignored.
  assign w_retire  = w_granted & w_resp & (w_count != '0);

  wb_outstanding_cnt #(
    .MAX (MAX_OUTSTANDING),
    .W   (CW)
  ) u_cnt (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_issue  (w_issue),
    .i_retire (w_retire),
    .i_clear  (w_release | w_tmo),
    .o_count  (w_count),
    .o_full   (w_full)
  );

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] r_wdog;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog <= 8'(TIMEOUT_CYCLES);
    end else if (!w_granted || w_resp || w_tmo) begin
      r_wdog <= 8'(TIMEOUT_CYCLES);
    end else if ((w_count != '0) && (r_wdog != 8'd0)) begin
      r_wdog <= r_wdog - 8'd1;
    end
  end

  assign w_tmo = w_granted & (r_wdog == 8'd0);
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          w_next = r_last ? GNT0 : GNT1;
        end else if (w_req0) begin
          w_next = GNT0;
        end else if (w_req1) begin
          w_next = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (w_release || w_tmo) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_release || w_tmo) begin
        r_last <= w_g1;
      end
    end
  end

endmodule
